seq_mem_d2_arbiter: RTL and testbench



---
 rtl/seq_mem_d2_arbiter_if.sv | 26 ++
 rtl/seq_mem_d2_arbiter.sv | 97 +++++++++
 tb/tb_seq_mem_d2_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_mem_d2_arbiter_if.sv
// One seq_mem_d2 port bundle: address, write data, held enables, returned data and done pulses.
// master = side that issues requests (client, or the arbiter toward memory); slave = side that serves them.
interface seq_mem_d2_arbiter_if #(
  parameter int D0_IDX_SIZE = 4,
  parameter int D1_IDX_SIZE = 4,
  parameter int WIDTH       = 32
);
  logic [D0_IDX_SIZE-1:0] addr0;
  logic [D1_IDX_SIZE-1:0] addr1;
  logic [WIDTH-1:0]       write_data;
  logic                   write_en;
  logic                   read_en;
  logic [WIDTH-1:0]       read_data;
  logic                   read_done;
  logic                   write_done;

  modport master (
    output addr0, addr1, write_data, write_en, read_en,
    input  read_data, read_done, write_done
  );

  modport slave (
    input  addr0, addr1, write_data, write_en, read_en,
    output read_data, read_done, write_done
  );
endinterface

// File: rtl/seq_mem_d2_arbiter.sv
// Round-robin arbiter sharing one seq_mem_d2 between two clients; one IDLE arbitration
// cycle per transaction, live pass-through of the owner's request while BUSY.
module seq_mem_d2_arbiter #(
  parameter int D0_IDX_SIZE = 4,
  parameter int D1_IDX_SIZE = 4,
  parameter int WIDTH       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_mem_d2_arbiter_if.slave  r0,
  seq_mem_d2_arbiter_if.slave  r1,
  seq_mem_d2_arbiter_if.master mem,
  output logic                 owner,
  output logic                 busy
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OP_READ, OP_WRITE} op_t;

  state_t state;
  op_t    op;
  logic   last;

  logic                   req0, req1, grant;
  op_t                    grant_op;
  logic [D0_IDX_SIZE-1:0] own_addr0;
  logic [D1_IDX_SIZE-1:0] own_addr1;
  logic [WIDTH-1:0]       own_wdata;
  logic                   own_re, own_we, txn_end;

  // On a tie the client that did not win last time is granted; write beats read within a client.
  always_comb begin
    req0     = r0.read_en | r0.write_en;
    req1     = r1.read_en | r1.write_en;
    grant    = (req0 && req1) ? ~last : req1;
    grant_op = (grant ? r1.write_en : r0.write_en) ? OP_WRITE : OP_READ;
  end

  always_comb begin
    own_addr0 = owner ? r1.addr0      : r0.addr0;
    own_addr1 = owner ? r1.addr1      : r0.addr1;
    own_wdata = owner ? r1.write_data : r0.write_data;
    own_re    = owner ? r1.read_en    : r0.read_en;
    own_we    = owner ? r1.write_en   : r0.write_en;
    // A transaction ends on its matching done, or when the owner withdraws the enable (abort).
    txn_end   = (op == OP_WRITE) ? (mem.write_done || !own_we)
                                 : (mem.read_done  || !own_re);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      op    <= OP_READ;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state <= BUSY;
            owner <= grant;
            last  <= grant;
            op    <= grant_op;
          end
        end
        BUSY: begin
          if (txn_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy           = (state == BUSY);
    mem.addr0      = '0;
    mem.addr1      = '0;
    mem.write_data = '0;
    mem.write_en   = 1'b0;
    mem.read_en    = 1'b0;
    if (busy) begin
      mem.addr0      = own_addr0;
      mem.addr1      = own_addr1;
      mem.write_data = own_wdata;
      mem.write_en   = (op == OP_WRITE) && own_we;
      mem.read_en    = (op == OP_READ)  && own_re;
    end
    r0.read_done  = busy && !owner && (op == OP_READ)  && mem.read_done;
    r0.write_done = busy && !owner && (op == OP_WRITE) && mem.write_done;
    r1.read_done  = busy &&  owner && (op == OP_READ)  && mem.read_done;
    r1.write_done = busy &&  owner && (op == OP_WRITE) && mem.write_done;
  end

  assign r0.read_data = mem.read_data;
  assign r1.read_data = mem.read_data;

endmodule

// File: tb/tb_seq_mem_d2_arbiter.sv
// Bench for seq_mem_d2_arbiter: cycle table, directed multi-cycle sequences, and randomized
// client traffic checked against a transaction-level memory/fairness model.
module tb_seq_mem_d2_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic owner, busy;

  always #5 clk = ~clk;

  seq_mem_d2_arbiter_if #(.D0_IDX_SIZE(4), .D1_IDX_SIZE(4), .WIDTH(32)) r0_if ();
  seq_mem_d2_arbiter_if #(.D0_IDX_SIZE(4), .D1_IDX_SIZE(4), .WIDTH(32)) r1_if ();
  seq_mem_d2_arbiter_if #(.D0_IDX_SIZE(4), .D1_IDX_SIZE(4), .WIDTH(32)) mem_if ();

  seq_mem_d2_arbiter #(.D0_IDX_SIZE(4), .D1_IDX_SIZE(4), .WIDTH(32)) dut (
    .clk(clk), .reset(reset), .r0(r0_if), .r1(r1_if), .mem(mem_if),
    .owner(owner), .busy(busy)
  );

  // 1-cycle memory: an enable seen at an edge yields a one-cycle done pulse in the next cycle.
  logic [31:0] mem_arr [16][16];
  logic        m_rd_done = 1'b0, m_wr_done = 1'b0;
  logic [31:0] m_rd_data = '0;
  logic        tbl_mode = 1'b0, tbl_rd_done = 1'b0, tbl_wr_done = 1'b0;
  logic        pl_en = 1'b0;
  logic [3:0]  pl_a0 = '0, pl_a1 = '0;
  logic [31:0] pl_d = '0;

  always @(posedge clk) begin
    if (pl_en) mem_arr[pl_a0][pl_a1] <= pl_d;
    m_rd_done <= mem_if.read_en && !m_rd_done;
    if (mem_if.read_en && !m_rd_done) m_rd_data <= mem_arr[mem_if.addr0][mem_if.addr1];
    m_wr_done <= mem_if.write_en && !m_wr_done;
    if (mem_if.write_en && !m_wr_done) mem_arr[mem_if.addr0][mem_if.addr1] <= mem_if.write_data;
  end

  assign mem_if.read_done  = tbl_mode ? tbl_rd_done : m_rd_done;
  assign mem_if.write_done = tbl_mode ? tbl_wr_done : m_wr_done;
  assign mem_if.read_data  = m_rd_data;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model state
  typedef struct packed {
    logic [1:0]  kind;  // 0 read, 1 write, 2 both enables (write expected)
    logic [3:0]  a0, a1;
    logic [31:0] d;
  } txn_t;

  logic [31:0] ref_mem [16][16];
  txn_t        q0[$], q1[$];
  txn_t        cur [2];
  logic        active [2];
  int          wait_cnt [2];
  int          done_log[$];

  task automatic preload(input logic [3:0] a0, input logic [3:0] a1, input logic [31:0] d);
    pl_en = 1'b1; pl_a0 = a0; pl_a1 = a1; pl_d = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[a0][a1] = d;
  endtask

  task automatic clear_clients();
    r0_if.read_en = 0; r0_if.write_en = 0; r0_if.addr0 = '0; r0_if.addr1 = '0; r0_if.write_data = '0;
    r1_if.read_en = 0; r1_if.write_en = 0; r1_if.addr0 = '0; r1_if.addr1 = '0; r1_if.write_data = '0;
  endtask

  task automatic drive_clients();
    clear_clients();
    if (active[0]) begin
      r0_if.addr0 = cur[0].a0; r0_if.addr1 = cur[0].a1; r0_if.write_data = cur[0].d;
      r0_if.read_en = (cur[0].kind != 2'd1); r0_if.write_en = (cur[0].kind != 2'd0);
    end
    if (active[1]) begin
      r1_if.addr0 = cur[1].a0; r1_if.addr1 = cur[1].a1; r1_if.write_data = cur[1].d;
      r1_if.read_en = (cur[1].kind != 2'd1); r1_if.write_en = (cur[1].kind != 2'd0);
    end
  endtask

  task automatic complete(input int k);
    int o;
    o = 1 - k;
    done_log.push_back(k);
    active[k]   = 1'b0;
    wait_cnt[k] = 0;
    if (active[o]) begin
      wait_cnt[o]++;
      chk($sformatf("fair_wait_c%0d", o), 64'(wait_cnt[o] <= 1), 64'd1);
    end
  endtask

  task automatic random_txn(output txn_t t);
    t.kind = 2'($urandom_range(0, 2));
    t.a0   = 4'($urandom_range(0, 3));
    t.a1   = 4'($urandom_range(0, 3));
    t.d    = $urandom;
  endtask

  // Clients issue queued transactions, hold enables until done, and the model checks each done.
  task automatic run_engine(input int gen_cycles, input int max_cycles);
    int   cyc;
    logic rd [2];
    logic wd [2];
    txn_t t;
    cyc = 0;
    active[0] = 0; active[1] = 0; wait_cnt[0] = 0; wait_cnt[1] = 0;
    while (1) begin
      if (cyc >= gen_cycles && q0.size() == 0 && q1.size() == 0 && !active[0] && !active[1]) break;
      if (cyc >= max_cycles) begin
        chk("engine_timeout", 64'd0, 64'd1);
        break;
      end
      @(posedge clk); #1;
      if (cyc < gen_cycles) begin
        if (q0.size() == 0 && !active[0] && $urandom_range(0, 3) == 0) begin random_txn(t); q0.push_back(t); end
        if (q1.size() == 0 && !active[1] && $urandom_range(0, 3) == 0) begin random_txn(t); q1.push_back(t); end
      end
      if (!active[0] && q0.size() > 0) begin cur[0] = q0.pop_front(); active[0] = 1'b1; end
      if (!active[1] && q1.size() > 0) begin cur[1] = q1.pop_front(); active[1] = 1'b1; end
      drive_clients();
      @(negedge clk);
      rd[0] = r0_if.read_done; wd[0] = r0_if.write_done;
      rd[1] = r1_if.read_done; wd[1] = r1_if.write_done;
      if (mem_if.read_en && mem_if.write_en) chk("mem_both_en", 64'd1, 64'd0);
      for (int k = 0; k < 2; k++) begin
        if (wd[k]) begin
          chk($sformatf("c%0d_wr_done_valid", k), 64'(active[k] && cur[k].kind != 2'd0 && !rd[k]), 64'd1);
          if (active[k] && cur[k].kind != 2'd0) ref_mem[cur[k].a0][cur[k].a1] = cur[k].d;
          if (active[k]) complete(k);
        end else if (rd[k]) begin
          chk($sformatf("c%0d_rd_done_valid", k), 64'(active[k] && cur[k].kind == 2'd0), 64'd1);
          if (active[k]) begin
            chk($sformatf("c%0d_rd_data", k), 64'(k == 0 ? r0_if.read_data : r1_if.read_data),
                64'(ref_mem[cur[k].a0][cur[k].a1]));
            complete(k);
          end
        end
      end
      cyc++;
    end
    @(posedge clk); #1;
    clear_clients();
  endtask

  // Cycle table: {r0_re, r0_we, r1_re, r1_we, mem_rd_done, mem_wr_done} and expected
  // {busy, owner, mem_re, mem_we, r0_rd_done, r0_wr_done, r1_rd_done, r1_wr_done}.
  typedef struct packed {
    logic [5:0] in;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [22];

  initial begin
    logic [7:0]  act_bits;
    logic [39:0] exp_bus, act_bus;

    tbl[0]  = {6'b100000, 8'b00000000};
    tbl[1]  = {6'b100000, 8'b10100000};
    tbl[2]  = {6'b100010, 8'b10101000};
    tbl[3]  = {6'b000000, 8'b00000000};
    tbl[4]  = {6'b000100, 8'b00000000};
    tbl[5]  = {6'b000110, 8'b11010000};
    tbl[6]  = {6'b100101, 8'b11010001};
    tbl[7]  = {6'b100000, 8'b01000000};
    tbl[8]  = {6'b100000, 8'b10100000};
    tbl[9]  = {6'b000000, 8'b10000000};
    tbl[10] = {6'b000000, 8'b00000000};
    tbl[11] = {6'b011000, 8'b00000000};
    tbl[12] = {6'b011000, 8'b11100000};
    tbl[13] = {6'b011010, 8'b11100010};
    tbl[14] = {6'b010000, 8'b01000000};
    tbl[15] = {6'b010000, 8'b10010000};
    tbl[16] = {6'b010001, 8'b10010100};
    tbl[17] = {6'b000000, 8'b00000000};
    tbl[18] = {6'b001100, 8'b00000000};
    tbl[19] = {6'b001100, 8'b11010000};
    tbl[20] = {6'b001111, 8'b11010001};
    tbl[21] = {6'b000000, 8'b01000000};

    // Reset with a live request: nothing may be granted or forwarded.
    clear_clients();
    reset = 1'b1;
    r1_if.write_en = 1'b1; r1_if.addr0 = 4'd5; r1_if.addr1 = 4'd6;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_en_done", 64'({mem_if.read_en, mem_if.write_en, r0_if.read_done, r0_if.write_done,
                            r1_if.read_done, r1_if.write_done}), 64'd0);
    chk("rst_addr", 64'({mem_if.addr0, mem_if.addr1, mem_if.write_data}), 64'd0);
    reset = 1'b0;
    clear_clients();
    repeat (2) @(posedge clk);

    // Table phase
    tbl_mode = 1'b1;
    r0_if.addr0 = 4'd2; r0_if.addr1 = 4'd3; r0_if.write_data = 32'h11;
    r1_if.addr0 = 4'd0; r1_if.addr1 = 4'd5; r1_if.write_data = 32'hA5;
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      {r0_if.read_en, r0_if.write_en, r1_if.read_en, r1_if.write_en, tbl_rd_done, tbl_wr_done} = tbl[i].in;
      @(negedge clk);
      act_bits = {busy, owner, mem_if.read_en, mem_if.write_en, r0_if.read_done, r0_if.write_done,
                  r1_if.read_done, r1_if.write_done};
      chk($sformatf("tbl_row%0d", i), 64'(act_bits), 64'(tbl[i].exp));
      exp_bus = !tbl[i].exp[7] ? 40'd0 : (tbl[i].exp[6] ? {4'd0, 4'd5, 32'hA5} : {4'd2, 4'd3, 32'h11});
      act_bus = {mem_if.addr0, mem_if.addr1, mem_if.write_data};
      chk($sformatf("tbl_bus%0d", i), 64'(act_bus), 64'(exp_bus));
    end
    @(posedge clk); #1;
    clear_clients(); tbl_rd_done = 1'b0; tbl_wr_done = 1'b0;
    repeat (2) @(posedge clk);
    tbl_mode = 1'b0;
    #1;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) preload(4'(a), 4'(b), 32'(a * 16 + b));

    // Tie after reset: r0 write wins, r1 read sees it, then r0's immediate re-request loses to r1.
    reset = 1'b1; repeat (2) @(posedge clk); #1; reset = 1'b0;
    done_log.delete();
    q0.push_back('{kind: 2'd1, a0: 4'd1, a1: 4'd1, d: 32'h11});
    q0.push_back('{kind: 2'd0, a0: 4'd1, a1: 4'd1, d: 32'h0});
    q1.push_back('{kind: 2'd0, a0: 4'd1, a1: 4'd1, d: 32'h0});
    run_engine(0, 60);
    chk("tie_count", 64'(done_log.size()), 64'd3);
    if (done_log.size() == 3) begin
      chk("tie_first_r0", 64'(done_log[0]), 64'd0);
      chk("tie_then_r1", 64'(done_log[1]), 64'd1);
      chk("tie_second_r0", 64'(done_log[2]), 64'd0);
    end

    // Both always requesting: grants strictly alternate, r1 first since r0 was last.
    done_log.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{kind: 2'd0, a0: 4'(i), a1: 4'd2, d: 32'h0});
      q1.push_back('{kind: 2'd0, a0: 4'd3, a1: 4'(i), d: 32'h0});
    end
    run_engine(0, 80);
    chk("alt_count", 64'(done_log.size()), 64'd8);
    for (int i = 0; i < done_log.size(); i++)
      chk($sformatf("alt_order%0d", i), 64'(done_log[i]), 64'((i % 2 == 0) ? 1 : 0));

    // Single read timing against the 1-cycle memory.
    preload(4'd2, 4'd3, 32'hDEADBEEF);
    r0_if.read_en = 1'b1; r0_if.addr0 = 4'd2; r0_if.addr1 = 4'd3;
    @(negedge clk);
    chk("sr_idle_before", 64'({busy, mem_if.read_en}), 64'd0);
    @(negedge clk);
    chk("sr_c1_en", 64'({busy, mem_if.read_en, mem_if.addr0, mem_if.addr1}), 64'({2'b11, 4'd2, 4'd3}));
    @(negedge clk);
    chk("sr_c2_done", 64'({r0_if.read_done, r1_if.read_done}), 64'b10);
    chk("sr_c2_data", 64'(r0_if.read_data), 64'hDEADBEEF);
    @(posedge clk); #1;
    r0_if.read_en = 1'b0;
    @(negedge clk);
    chk("sr_c3_idle", 64'(busy), 64'd0);

    // Reset in the BUSY cycle before done: transaction dropped, stray done not routed.
    @(posedge clk); #1;
    r0_if.read_en = 1'b1; r0_if.addr0 = 4'd1; r0_if.addr1 = 4'd2;
    @(negedge clk);
    @(negedge clk);
    chk("rm_busy_pre", 64'({busy, mem_if.read_en}), 64'b11);
    reset = 1'b1;
    @(negedge clk);
    chk("rm_idle", 64'({busy, owner, mem_if.read_en, mem_if.write_en}), 64'd0);
    chk("rm_no_done", 64'({mem_if.read_done, r0_if.read_done, r1_if.read_done}), 64'b100);
    reset = 1'b0;
    r0_if.read_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Randomized traffic
    done_log.delete();
    run_engine(1500, 4000);
    chk("rand_progress", 64'(done_log.size() > 50), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
